// File: rtl/dict_fifo_update.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dict_fifo_update                                              |
// | Purpose  : Decompressor dictionary store. Pushes freshly decoded words    |
// |            into a WORD-entry dictionary with FIFO (round-robin)           |
// |            replacement and clears it sequentially on a flush request.    |
// | Options  : DICT_PUSH_STATS_EN builds the 16-bit saturating push counter  |
// |            (otherwise o_push_cnt is tied to zero).                        |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dict_fifo_update #(
  parameter int WORD  = 16,
  parameter int WIDTH = 32,
  parameter int CODES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [CODES-1:0]         i_codes,
  input  logic [CODES-1:0]         i_codes_bak,
  input  logic [WIDTH-1:0]         i_word,
  input  logic                     i_flush,
  output logic [WORD*WIDTH-1:0]    o_dict,
  output logic [$clog2(WORD):0]    o_count,
  output logic                     o_busy,
  output logic [15:0]              o_push_cnt
);

  localparam int AW = $clog2(WORD);
  localparam logic [AW-1:0]  C_LAST = AW'(WORD - 1);
  localparam logic [AW:0]    C_FULL = (AW + 1)'(WORD);
  localparam logic [CODES-1:0] C_UNCOMP = CODES'(1);
  localparam logic [CODES-1:0] C_ESCAPE = CODES'(3);
  localparam logic [CODES-1:0] C_ZEXT   = CODES'(1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [WORD];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_clr_idx;
  logic [AW:0]      r_count;
  logic             w_push_code;
  logic             w_push;
  logic             w_clear_done;

  // Codes that carry a new word into the dictionary: uncompressed, or any
  // escape sub-code except the zero-extended byte.
  assign w_push_code  = (i_codes == C_UNCOMP) ||
                        ((i_codes == C_ESCAPE) && (i_codes_bak != C_ZEXT));
  assign w_push       = i_valid && o_ready && w_push_code;
  assign w_clear_done = (r_state == CLEAR) && (r_clr_idx == C_LAST);
  assign o_busy       = (r_state == CLEAR);
  assign o_count      = r_count;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state and ready; ready depends only on state and flush.
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    case (r_state)
      RUN: begin
        o_ready = !i_flush;
        if (i_flush) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        if (r_clr_idx == C_LAST) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Dictionary storage, write pointer, fill count and clear index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < WORD; k++) r_mem[k] <= '0;
      r_wr_ptr  <= '0;
      r_clr_idx <= '0;
      r_count   <= '0;
    end else if (r_state == CLEAR) begin
      r_mem[r_clr_idx] <= '0;
      r_clr_idx        <= r_clr_idx + 1'b1;
      if (w_clear_done) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
      end
    end else if (i_flush) begin
      r_clr_idx <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_word;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
      if (r_count != C_FULL) r_count <= r_count + 1'b1;
    end
  end

  for (genvar k = 0; k < WORD; k++) begin : g_dict
    assign o_dict[k*WIDTH +: WIDTH] = r_mem[k];
  end

`ifdef DICT_PUSH_STATS_EN
  logic [15:0] r_push_cnt;

  // Saturating push counter, cleared with the dictionary.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_clear_done)               r_push_cnt <= '0;
    else if (w_push && (r_push_cnt != 16'hFFFF)) r_push_cnt <= r_push_cnt + 16'd1;
  end

  assign o_push_cnt = r_push_cnt;
`else
  assign o_push_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dict_fifo_update.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dict_fifo_update                                           |
// | Purpose  : Directed self-checking bench for dict_fifo_update.            |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dict_fifo_update;

  localparam int WORD  = 16;
  localparam int WIDTH = 32;
  localparam int CODES = 2;
  localparam int CW    = $clog2(WORD) + 1;

  logic                  clk;
  logic                  rst;
  logic                  valid;
  logic                  ready;
  logic [CODES-1:0]      codes;
  logic [CODES-1:0]      codes_bak;
  logic [WIDTH-1:0]      word;
  logic                  flush;
  logic [WORD*WIDTH-1:0] dict;
  logic [CW-1:0]         count;
  logic                  busy;
  logic [15:0]           push_cnt;

  int checks = 0;
  int errors = 0;

  dict_fifo_update #(.WORD(WORD), .WIDTH(WIDTH), .CODES(CODES)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_codes     (codes),
    .i_codes_bak (codes_bak),
    .i_word      (word),
    .i_flush     (flush),
    .o_dict      (dict),
    .o_count     (count),
    .o_busy      (busy),
    .o_push_cnt  (push_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ent(input int k);
    return dict[k*WIDTH +: WIDTH];
  endfunction

  // Expected push counter value depending on the build option.
  function automatic logic [15:0] exp_pc(input int n);
`ifdef DICT_PUSH_STATS_EN
    return 16'(n);
`else
    return 16'(0 * n);
`endif
  endfunction

  // Decoder model: a full-match (code 10) returns the addressed entry.
  function automatic logic [WIDTH-1:0] decode_match(input int idx);
    return dict[idx*WIDTH +: WIDTH];
  endfunction

  initial begin
    rst = 1'b1; valid = 1'b0; codes = '0; codes_bak = '0; word = '0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_dict_zero", 64'(dict === '0), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_push_cnt", 64'(push_cnt), 64'd0);

    // Three uncompressed pushes, each visible one edge later
    valid = 1'b1; codes = 2'b01;
    word = 32'h11; tick();
    check("push0_e0", 64'(ent(0)), 64'h11);
    check("push0_cnt", 64'(count), 64'd1);
    word = 32'h22; tick();
    check("push1_e1", 64'(ent(1)), 64'h22);
    word = 32'h33; tick();
    check("push2_e2", 64'(ent(2)), 64'h33);
    check("push2_cnt", 64'(count), 64'd3);
    check("push2_pc", 64'(push_cnt), 64'(exp_pc(3)));

    // Non-push codes leave the dictionary untouched
    word = 32'hDEADBEEF;
    codes = 2'b00; codes_bak = 2'b00; tick();
    check("np00_ready", 64'(ready), 64'd1);
    codes = 2'b10; tick();
    check("np10_ready", 64'(ready), 64'd1);
    codes = 2'b11; codes_bak = 2'b01; tick();
    check("np1101_ready", 64'(ready), 64'd1);
    check("np_e0", 64'(ent(0)), 64'h11);
    check("np_e2", 64'(ent(2)), 64'h33);
    check("np_e3", 64'(ent(3)), 64'h0);
    check("np_cnt", 64'(count), 64'd3);

    // Flush with a valid push pending in the same cycle
    codes = 2'b01; codes_bak = 2'b00; word = 32'hAAAA; flush = 1'b1;
    #1;
    check("flush_req_ready", 64'(ready), 64'd0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < WORD; i++) begin
      check($sformatf("clr%0d_busy", i), 64'(busy), 64'd1);
      check($sformatf("clr%0d_ready", i), 64'(ready), 64'd0);
      tick();
    end
    check("clr_done_busy", 64'(busy), 64'd0);
    check("clr_done_ready", 64'(ready), 64'd1);
    check("clr_done_dict", 64'(dict === '0), 64'd1);
    check("clr_done_cnt", 64'(count), 64'd0);
    check("clr_done_pc", 64'(push_cnt), 64'd0);
    tick();
    check("post_clr_e0", 64'(ent(0)), 64'hAAAA);
    check("post_clr_cnt", 64'(count), 64'd1);
    valid = 1'b0;

    // Reset back to empty, then 18 pushes across all push codes
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_dict", 64'(dict === '0), 64'd1);
    valid = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      case (n % 4)
        0: begin codes = 2'b01; codes_bak = 2'b01; end
        1: begin codes = 2'b11; codes_bak = 2'b00; end
        2: begin codes = 2'b11; codes_bak = 2'b10; end
        default: begin codes = 2'b11; codes_bak = 2'b11; end
      endcase
      word = 32'(n);
      tick();
      if (n == 16) check("wrap16_cnt", 64'(count), 64'd16);
    end
    valid = 1'b0;
    check("wrap_e0", 64'(ent(0)), 64'd17);
    check("wrap_e1", 64'(ent(1)), 64'd18);
    for (int k = 2; k < WORD; k++) check($sformatf("wrap_e%0d", k), 64'(ent(k)), 64'(k + 1));
    check("wrap_cnt", 64'(count), 64'd16);
    check("wrap_pc", 64'(push_cnt), 64'(exp_pc(18)));

    // Reset during the fifth clear cycle
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); tick(); tick(); tick();
    check("midclr_busy", 64'(busy), 64'd1);
    check("midclr_e0", 64'(ent(0)), 64'd0);
    check("midclr_e3", 64'(ent(3)), 64'd0);
    check("midclr_e5", 64'(ent(5)), 64'd6);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_dict", 64'(dict === '0), 64'd0 + 64'd1);
    check("midrst_cnt", 64'(count), 64'd0);
    check("midrst_pc", 64'(push_cnt), 64'd0);

    // Back-to-back push then full-match decode of the new entry
    valid = 1'b1; codes = 2'b01; word = 32'hCAFEF00D; tick();
    codes = 2'b10; word = 32'h0;
    check("b2b_decode", 64'(decode_match(0)), 64'hCAFEF00D);
    tick();
    valid = 1'b0;
    check("b2b_cnt", 64'(count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
